// File: rtl/fu_issue_scheduler_pkg.sv
// rtl/fu_issue_scheduler_pkg.sv - shared processor types: FU classes, FU count and busy-vector indices
package fu_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MULT   = 2'd1,
    FU_BRANCH = 2'd2,
    FU_MEM    = 2'd3
  } fu_type_e;

  localparam int DEFAULT_NUM_ALU = 2;
  localparam int NUM_FU          = DEFAULT_NUM_ALU + 3;

  // Busy-vector layout: ALU0..ALUn-1, then MULT, BRANCH, MEM.
  function automatic int fu_mult_idx(input int num_alu);
    return num_alu;
  endfunction

  function automatic int fu_br_idx(input int num_alu);
    return num_alu + 1;
  endfunction

  function automatic int fu_mem_idx(input int num_alu);
    return num_alu + 2;
  endfunction

endpackage

// File: rtl/fu_issue_scheduler_rr_picker.sv
// rtl/fu_issue_scheduler_rr_picker.sv - round-robin picker: first set request at or after ptr, wrapping
module rr_picker #(
  parameter int N = 16,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_issue_scheduler.sv
// rtl/fu_issue_scheduler.sv - per-class round-robin issue scheduler for ALU/MULT/BRANCH/MEM units
// FU_SCHED_MULT_PIPELINED_EN selects a fully pipelined multiplier (no occupancy counter).
module fu_issue_scheduler
  import fu_issue_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int NUM_ALU  = 2,
  parameter int MULT_LAT = 4,
  localparam int NFU = NUM_ALU + 3,
  localparam int PW  = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic     [RS_SIZE-1:0]            rs_ready,
  input  fu_type_e [RS_SIZE-1:0]            rs_fu_type,
  input  logic                              mem_ready,
  input  logic                              squash,
  output logic     [NUM_ALU-1:0][RS_SIZE-1:0] alu_grant,
  output logic     [RS_SIZE-1:0]            mult_grant,
  output logic     [RS_SIZE-1:0]            br_grant,
  output logic     [RS_SIZE-1:0]            mem_grant,
  output logic     [NFU-1:0]                fu_busy_out
);

  localparam int MULT_I = fu_mult_idx(NUM_ALU);
  localparam int BR_I   = fu_br_idx(NUM_ALU);
  localparam int MEM_I  = fu_mem_idx(NUM_ALU);

  function automatic logic [PW-1:0] next_ptr(input logic [RS_SIZE-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (oh[i]) idx = idx | PW'(i);
    end
    return (idx == PW'(RS_SIZE-1)) ? '0 : idx + PW'(1);
  endfunction

  logic [PW-1:0]      alu_ptr, mult_ptr, br_ptr, mem_ptr;
  logic [RS_SIZE-1:0] elig_alu, elig_mult, elig_br, elig_mem;
  logic [RS_SIZE-1:0] alu_last;
  logic [NUM_ALU-1:0] alu_valid;
  logic               mult_valid, br_valid, mem_valid;
  logic               mult_free, mult_busy_next;
  logic               gate;

  assign gate = reset | squash;

  always_comb begin
    elig_alu  = '0;
    elig_mult = '0;
    elig_br   = '0;
    elig_mem  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      elig_alu[i]  = rs_ready[i] && (rs_fu_type[i] == FU_ALU)    && !gate;
      elig_mult[i] = rs_ready[i] && (rs_fu_type[i] == FU_MULT)   && !gate && mult_free;
      elig_br[i]   = rs_ready[i] && (rs_fu_type[i] == FU_BRANCH) && !gate;
      elig_mem[i]  = rs_ready[i] && (rs_fu_type[i] == FU_MEM)    && !gate && mem_ready;
    end
  end

  // Each ALU slot sees the requests left over by the slots before it.
  for (genvar k = 0; k < NUM_ALU; k++) begin : gen_alu
    logic [RS_SIZE-1:0] avail;
    logic [RS_SIZE-1:0] g;
    logic               v;
    if (k == 0) begin : gen_first
      assign avail = elig_alu;
    end else begin : gen_chain
      assign avail = gen_alu[k-1].avail & ~gen_alu[k-1].g;
    end
    rr_picker #(.N(RS_SIZE)) u_pick (.req(avail), .ptr(alu_ptr), .grant(g), .valid(v));
    assign alu_grant[k] = g;
    assign alu_valid[k] = v;
  end

  rr_picker #(.N(RS_SIZE)) u_mult (.req(elig_mult), .ptr(mult_ptr), .grant(mult_grant), .valid(mult_valid));
  rr_picker #(.N(RS_SIZE)) u_br   (.req(elig_br),   .ptr(br_ptr),   .grant(br_grant),   .valid(br_valid));
  rr_picker #(.N(RS_SIZE)) u_mem  (.req(elig_mem),  .ptr(mem_ptr),  .grant(mem_grant),  .valid(mem_valid));

  // Later ALU slots always land further along the round-robin order.
  always_comb begin
    alu_last = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      if (alu_valid[k]) alu_last = alu_grant[k];
    end
  end

`ifdef FU_SCHED_MULT_PIPELINED_EN
  assign mult_free      = 1'b1;
  assign mult_busy_next = mult_valid;
`else
  logic [3:0] mult_cnt, mult_cnt_next;

  assign mult_free = (mult_cnt == 4'd0);

  always_comb begin
    mult_cnt_next = mult_cnt;
    if (mult_valid)            mult_cnt_next = 4'(MULT_LAT - 1);
    else if (mult_cnt != 4'd0) mult_cnt_next = mult_cnt - 4'd1;
  end

  assign mult_busy_next = (mult_cnt_next != 4'd0);

  always_ff @(posedge clock) begin
    if (reset) mult_cnt <= 4'd0;
    else       mult_cnt <= mult_cnt_next;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_ptr     <= '0;
      mult_ptr    <= '0;
      br_ptr      <= '0;
      mem_ptr     <= '0;
      fu_busy_out <= '0;
    end else begin
      if (alu_valid[0]) alu_ptr  <= next_ptr(alu_last);
      if (mult_valid)   mult_ptr <= next_ptr(mult_grant);
      if (br_valid)     br_ptr   <= next_ptr(br_grant);
      if (mem_valid)    mem_ptr  <= next_ptr(mem_grant);
      fu_busy_out[NUM_ALU-1:0] <= alu_valid;
      fu_busy_out[MULT_I]      <= mult_busy_next;
      fu_busy_out[BR_I]        <= br_valid;
      fu_busy_out[MEM_I]       <= mem_valid;
    end
  end

endmodule
